sdram_host_arbiter: RTL and testbench

//  Shares the single 32-bit host port of the 32->16 SDRAM bridge between an instruction fetch port (read-only)
//  and a data port (read/write). Registered round-robin grant; latches the winning request and holds it stable
//  for the whole transfer; returns read data and a one-cycle completion to the owner. Optional watchdog ends hung transfers.

---
 rtl/sdram_host_arbiter_pkg.sv | 19 +
 rtl/sdram_arb_watchdog.sv | 36 +++
 rtl/sdram_host_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_host_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_host_arbiter_pkg.sv
// Shared types for the SDRAM host-port arbiter: FSM states, port ownership, bus widths.
package sdram_host_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int BSEL_W = 4;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Transfer watchdog: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES=0 disables it entirely.
module sdram_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt;

            // cnt holds the number of enabled cycles already elapsed, so the
            // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
            assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && !expired) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the bridge host port between the instruction
// (read-only) and data ports; latches the winner and holds it for the transfer.
module sdram_host_arbiter
    import sdram_host_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cs,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BSEL_W-1:0] i_bytesel,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_compl,
    output logic              i_err,
    input  logic              d_cs,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BSEL_W-1:0] d_bytesel,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_wr_en,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_compl,
    output logic              d_err,
    output logic              m_cs,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wr_en,
    output logic [BSEL_W-1:0] m_bytesel,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_compl
);

    arb_state_t        state, state_nxt;
    owner_t            owner, last_grant, winner;
    logic              i_req, d_req;
    logic              grant_valid, grant_d, fin, timeout, expired;
    logic [DATA_W-1:0] rd_val;

    assign i_req = i_cs && (|i_bytesel);
    assign d_req = d_cs && (|d_bytesel);

    sdram_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_valid),
        .enable (state == ARB_BUSY),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (grant_valid) state_nxt = ARB_BUSY;
            ARB_BUSY: if (fin)         state_nxt = ARB_DONE;
            ARB_DONE:                  state_nxt = ARB_IDLE;
            default:                   state_nxt = ARB_IDLE;
        endcase
    end

    // Decisions for this cycle; the register block below applies them at the edge.
    always_comb begin
        grant_valid = (state == ARB_IDLE) && (i_req || d_req);
        if (ROUND_ROBIN != 0) begin
            grant_d = d_req && (!i_req || (last_grant == OWNER_I));
        end else begin
            grant_d = d_req;
        end
        winner  = grant_d ? OWNER_D : OWNER_I;
        fin     = (state == ARB_BUSY) && (m_compl || expired);
        timeout = (state == ARB_BUSY) && !m_compl && expired;
        rd_val  = (timeout || m_wr_en) ? '0 : m_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cs       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wr_en    <= 1'b0;
            m_bytesel  <= '0;
            owner      <= OWNER_I;
            last_grant <= OWNER_I;
            i_rdata    <= '0;
            i_compl    <= 1'b0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_compl    <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            i_rdata <= '0;
            i_compl <= 1'b0;
            i_err   <= 1'b0;
            d_rdata <= '0;
            d_compl <= 1'b0;
            d_err   <= 1'b0;
            if (grant_valid) begin
                m_cs       <= 1'b1;
                m_addr     <= grant_d ? d_addr    : i_addr;
                m_bytesel  <= grant_d ? d_bytesel : i_bytesel;
                m_wdata    <= grant_d ? d_wdata   : '0;
                m_wr_en    <= grant_d ? d_wr_en   : 1'b0;
                owner      <= winner;
                last_grant <= winner;
            end else if (fin) begin
                // Bridge must see m_cs low as it returns to idle.
                m_cs      <= 1'b0;
                m_bytesel <= '0;
                if (owner == OWNER_D) begin
                    d_compl <= 1'b1;
                    d_err   <= timeout;
                    d_rdata <= rd_val;
                end else begin
                    i_compl <= 1'b1;
                    i_err   <= timeout;
                    i_rdata <= rd_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter with a simple delay-programmable bridge model.
module tb_sdram_host_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cs;
    logic [29:0] i_addr;
    logic [3:0]  i_bytesel;
    logic [31:0] i_rdata;
    logic        i_compl, i_err;
    logic        d_cs;
    logic [29:0] d_addr;
    logic [3:0]  d_bytesel;
    logic [31:0] d_wdata;
    logic        d_wr_en;
    logic [31:0] d_rdata;
    logic        d_compl, d_err;
    logic        m_cs;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_wr_en;
    logic [3:0]  m_bytesel;
    logic [31:0] m_rdata;
    logic        m_compl;

    int          checks = 0;
    int          failures = 0;

    // Bridge model: completes when m_cs has been high for bridge_delay cycles.
    logic        bridge_en;
    int          bridge_delay;
    logic [31:0] bridge_rdata;
    int          bcnt = 0;

    always @(posedge clk) bcnt <= m_cs ? bcnt + 1 : 0;
    assign m_compl = bridge_en && m_cs && (bcnt == bridge_delay - 1);
    assign m_rdata = bridge_rdata;

    always #5 clk = ~clk;

    sdram_host_arbiter #(.TIMEOUT_CYCLES(8), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .i_cs(i_cs), .i_addr(i_addr), .i_bytesel(i_bytesel),
        .i_rdata(i_rdata), .i_compl(i_compl), .i_err(i_err),
        .d_cs(d_cs), .d_addr(d_addr), .d_bytesel(d_bytesel),
        .d_wdata(d_wdata), .d_wr_en(d_wr_en),
        .d_rdata(d_rdata), .d_compl(d_compl), .d_err(d_err),
        .m_cs(m_cs), .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .m_rdata(m_rdata), .m_compl(m_compl)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        i_cs = 1'b1; i_addr = 30'h0000AAA; i_bytesel = 4'hF;
        d_cs = 1'b1; d_addr = 30'h0000BBB; d_bytesel = 4'hF; d_wdata = 32'h0; d_wr_en = 1'b0;
        bridge_en = 1'b1; bridge_delay = 2; bridge_rdata = 32'h0BADF00D;
        tick; tick;
        checks++;
        if ({m_cs, m_addr, m_wdata, m_wr_en, m_bytesel, i_compl, i_err, i_rdata,
             d_compl, d_err, d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs m_cs=%b m_addr=%h i_compl=%b d_compl=%b i_rdata=%h d_rdata=%h required all 0",
                     m_cs, m_addr, i_compl, d_compl, i_rdata, d_rdata);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (m_cs !== 1'b1) begin
            failures++; $display("FAIL reset_first_grant m_cs=%b required=1", m_cs);
        end
        checks++;
        if (m_addr !== 30'h0000BBB) begin
            failures++; $display("FAIL reset_first_owner m_addr=%h required=%h", m_addr, 30'h0000BBB);
        end
        n = 0;
        while (!d_compl && n < 20) begin tick; n++; end
        checks++;
        if (d_compl !== 1'b1) begin
            failures++; $display("FAIL reset_first_compl d_compl=%b required=1", d_compl);
        end
        i_cs = 1'b0; d_cs = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_instr_read;
        int          lat;
        logic        dseen, err;
        logic [31:0] rd;
        logic [29:0] ma;
        lat = 0; dseen = 1'b0; err = 1'b1; rd = '0; ma = '0;
        bridge_en = 1'b1; bridge_delay = 5; bridge_rdata = 32'hDEADBEEF;
        i_cs = 1'b1; i_addr = 30'h0000100; i_bytesel = 4'hF;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (d_compl) dseen = 1'b1;
            if (i_compl) begin lat = c; rd = i_rdata; err = i_err; ma = m_addr; break; end
        end
        i_cs = 1'b0;
        checks++;
        if (lat != 6) begin
            failures++; $display("FAIL instr_latency cycles=%0d required=6", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++; $display("FAIL instr_rdata i_rdata=%h required=deadbeef", rd);
        end
        checks++;
        if (err !== 1'b0 || dseen !== 1'b0) begin
            failures++; $display("FAIL instr_err_dcompl i_err=%b d_compl_seen=%b required 0/0", err, dseen);
        end
        checks++;
        if (ma !== 30'h0000100) begin
            failures++; $display("FAIL instr_addr m_addr=%h required=100", ma);
        end
        tick;
        checks++;
        if (i_compl !== 1'b0 || i_rdata !== 32'h0) begin
            failures++; $display("FAIL instr_rdata_clear i_compl=%b i_rdata=%h required 0/0", i_compl, i_rdata);
        end
        tick; tick;
    endtask

    task automatic test_bytesel_zero;
        logic granted;
        granted = 1'b0;
        i_cs = 1'b1; i_addr = 30'h0000200; i_bytesel = 4'h0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (m_cs) granted = 1'b1;
        end
        i_cs = 1'b0;
        checks++;
        if (granted !== 1'b0) begin
            failures++; $display("FAIL bytesel_zero m_cs_seen=%b required=0", granted);
        end
    endtask

    task automatic test_round_robin;
        logic [29:0] gaddr [4];
        int          ng, ic, dc, lowrun, badgap;
        logic        prev;
        ng = 0; ic = 0; dc = 0; lowrun = 0; badgap = 0;
        for (int k = 0; k < 4; k++) gaddr[k] = '0;
        bridge_en = 1'b1; bridge_delay = 2; bridge_rdata = 32'h55AA55AA;
        i_cs = 1'b1; i_addr = 30'h0000111; i_bytesel = 4'hF;
        d_cs = 1'b1; d_addr = 30'h0000222; d_bytesel = 4'hF; d_wr_en = 1'b0;
        prev = m_cs;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            tick;
            if (i_compl) ic++;
            if (d_compl) dc++;
            if (m_cs && !prev) begin
                if (ng > 0 && lowrun != 2) badgap = lowrun;
                gaddr[ng] = m_addr;
                ng++;
            end
            lowrun = m_cs ? 0 : lowrun + 1;
            prev = m_cs;
        end
        i_cs = 1'b0; d_cs = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (i_compl) ic++;
            if (d_compl) dc++;
        end
        checks++;
        if (ng != 4) begin
            failures++; $display("FAIL rr_grant_count grants=%0d required=4", ng);
        end
        checks++;
        if (gaddr[0] !== 30'h222 || gaddr[1] !== 30'h111 || gaddr[2] !== 30'h222 || gaddr[3] !== 30'h111) begin
            failures++;
            $display("FAIL rr_order addrs=%h,%h,%h,%h required=222,111,222,111",
                     gaddr[0], gaddr[1], gaddr[2], gaddr[3]);
        end
        checks++;
        if (ic != 2 || dc != 2) begin
            failures++; $display("FAIL rr_compl_counts i=%0d d=%0d required 2/2", ic, dc);
        end
        checks++;
        if (badgap != 0) begin
            failures++; $display("FAIL rr_gap low_cycles=%0d required=2", badgap);
        end
    endtask

    task automatic test_data_write;
        logic held;
        held = 1'b1;
        bridge_en = 1'b1; bridge_delay = 5; bridge_rdata = 32'hCAFEF00D;
        d_cs = 1'b1; d_addr = 30'h0ABCDEF; d_bytesel = 4'hC; d_wdata = 32'h12345678; d_wr_en = 1'b1;
        tick;
        checks++;
        if (m_cs !== 1'b1 || m_wr_en !== 1'b1) begin
            failures++; $display("FAIL wr_grant m_cs=%b m_wr_en=%b required 1/1", m_cs, m_wr_en);
        end
        tick;
        d_cs = 1'b0; d_bytesel = 4'h0; d_wdata = 32'hFFFFFFFF; d_wr_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!m_cs) break;
            if (m_wdata !== 32'h12345678 || m_bytesel !== 4'hC || m_addr !== 30'h0ABCDEF || m_wr_en !== 1'b1)
                held = 1'b0;
            tick;
        end
        checks++;
        if (held !== 1'b1) begin
            failures++; $display("FAIL wr_hold latched_fields_stable=%b required=1", held);
        end
        checks++;
        if (d_compl !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0 || i_compl !== 1'b0) begin
            failures++;
            $display("FAIL wr_compl d_compl=%b d_rdata=%h d_err=%b i_compl=%b required 1/0/0/0",
                     d_compl, d_rdata, d_err, i_compl);
        end
        checks++;
        if (m_bytesel !== 4'h0) begin
            failures++; $display("FAIL wr_bytesel_drop m_bytesel=%h required=0", m_bytesel);
        end
        tick; tick;
    endtask

    task automatic test_watchdog;
        int n;
        bridge_en = 1'b0; bridge_rdata = 32'h77777777;
        i_cs = 1'b1; i_addr = 30'h0000333; i_bytesel = 4'hF;
        tick;
        n = 0;
        if (m_cs) begin
            n = 1;
            for (int c = 0; c < 40; c++) begin
                tick;
                if (m_cs) n++;
                else break;
            end
        end
        i_cs = 1'b0;
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL wd_busy_cycles m_cs_cycles=%0d required=8", n);
        end
        checks++;
        if (i_compl !== 1'b1 || i_err !== 1'b1 || i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wd_expiry i_compl=%b i_err=%b i_rdata=%h required 1/1/0", i_compl, i_err, i_rdata);
        end
        tick;
        checks++;
        if (i_compl !== 1'b0 || i_err !== 1'b0) begin
            failures++; $display("FAIL wd_pulse_width i_compl=%b i_err=%b required 0/0", i_compl, i_err);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int n;
        bridge_en = 1'b1; bridge_delay = 5; bridge_rdata = 32'h13579BDF;
        d_cs = 1'b1; d_addr = 30'h0000444; d_bytesel = 4'hF; d_wr_en = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        #1;
        checks++;
        if (m_cs !== 1'b0 || m_addr !== 30'h0 || d_compl !== 1'b0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid m_cs=%b m_addr=%h d_compl=%b d_rdata=%h required all 0",
                     m_cs, m_addr, d_compl, d_rdata);
        end
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (m_cs !== 1'b1 || m_addr !== 30'h0000444) begin
            failures++; $display("FAIL rst_regrant m_cs=%b m_addr=%h required 1/444", m_cs, m_addr);
        end
        n = 0;
        while (!d_compl && n < 20) begin tick; n++; end
        checks++;
        if (d_compl !== 1'b1 || d_rdata !== 32'h13579BDF) begin
            failures++; $display("FAIL rst_post_compl d_compl=%b d_rdata=%h required 1/13579bdf", d_compl, d_rdata);
        end
        d_cs = 1'b0;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_instr_read;
        test_bytesel_zero;
        test_round_robin;
        test_data_write;
        test_watchdog;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
